// File: rtl/prime_pkg.sv
// Shared definitions for the prime counter: controller states, the prime
// constants and the next-prime map used by both controller and datapath.
package prime_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] P2  = 4'd2;
    localparam logic [3:0] P3  = 4'd3;
    localparam logic [3:0] P5  = 4'd5;
    localparam logic [3:0] P7  = 4'd7;
    localparam logic [3:0] P11 = 4'd11;
    localparam logic [3:0] P13 = 4'd13;

    // Successor in the 2..13 prime ring; any value off the ring falls back
    // to 2 so a corrupted register recovers on the next advance.
    function automatic logic [3:0] next_prime(input logic [3:0] p);
        logic [3:0] n;
        case (p)
            P2:      n = P3;
            P3:      n = P5;
            P5:      n = P7;
            P7:      n = P11;
            P11:     n = P13;
            P13:     n = P2;
            default: n = P2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/prime_step.sv
// Combinational next-prime step with a wrap flag for the 13 -> 2 transition.
// Kept standalone so the T-flip-flop datapath can reuse the same map.
module prime_step
    import prime_pkg::*;
(
    input  logic [3:0] prime,
    output logic [3:0] prime_next,
    output logic       wrap
);

    // Successor value and ring-wrap indication
    always_comb begin
        prime_next = next_prime(prime);
        wrap       = (prime == P13);
    end

endmodule

// File: rtl/prime_seq_ctrl.sv
// Sequencing controller for the 4-bit prime counter. Steps the prime
// register on each accepted handshake, in continuous or fixed-length burst
// mode, and reports busy / done / wrap count.
//
// Handshake: out_valid is decoded from the registered RUN state only, so it
// never depends on out_ready. A transfer happens on a rising edge where
// out_valid && out_ready; until then prime is held stable. stop withdraws
// out_valid without a transfer unless out_ready is high in that same cycle.
module prime_seq_ctrl
    import prime_pkg::*;
#(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              burst,
    input  logic              rewind,
    input  logic [STEP_W-1:0] steps,
    input  logic              stop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        prime,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] wrap_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic              burst_mode;
    logic [STEP_W-1:0] remaining;
    logic [3:0]        prime_next;
    logic              wrap;
    logic              hs;
    logic              last_step;

    prime_step u_step (
        .prime      (prime),
        .prime_next (prime_next),
        .wrap       (wrap)
    );

    assign hs        = (state == RUN) && out_ready;
    assign last_step = burst_mode && (remaining == STEP_W'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; stop outranks a burst-ending handshake (no done pulse)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (burst && (steps == '0)) state_nxt = DONE;
                    else                        state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop)                   state_nxt = IDLE;
                else if (hs && last_step)   state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        out_valid = (state == RUN);
        busy      = (state == RUN);
        done      = (state == DONE);
    end

    // Datapath: launch-time latching and per-handshake advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime      <= P2;
            remaining  <= '0;
            wrap_cnt   <= '0;
            burst_mode <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                burst_mode <= burst;
                remaining  <= steps;
                wrap_cnt   <= '0;
                if (rewind) prime <= P2;
            end else if (hs) begin
                prime <= prime_next;
                if (wrap)       wrap_cnt  <= wrap_cnt + STEP_W'(1);
                if (burst_mode) remaining <= remaining - STEP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prime_seq_ctrl.sv
// Self-checking bench for prime_seq_ctrl: directed scenarios followed by
// randomized launches compared against a ring-index reference model.
module tb_prime_seq_ctrl;

    localparam int STEP_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              burst = 1'b0;
    logic              rewind = 1'b0;
    logic [STEP_W-1:0] steps = '0;
    logic              stop = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [3:0]        prime;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] wrap_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: the prime ring as a plain table, position tracked by index
    int ring[6] = '{2, 3, 5, 7, 11, 13};
    int m_idx   = 0;
    logic [3:0] exp_q[$];

    prime_seq_ctrl #(.STEP_W(STEP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst     (burst),
        .rewind    (rewind),
        .steps     (steps),
        .stop      (stop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prime     (prime),
        .busy      (busy),
        .done      (done),
        .wrap_cnt  (wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic launch(input logic b, input logic rw, input int st);
        burst  = b;
        rewind = rw;
        steps  = STEP_W'(st);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        rewind = 1'b0;
    endtask

    initial begin
        int hs_cnt;
        int cyc;
        bit ended;
        bit exp_done;
        bit b;
        bit rdy;
        bit stp;
        int st;

        // ---- reset state
        tick(); tick();
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_prime", prime, 2);
        rst = 1'b0;
        tick();
        check("rst_done", done, 0);
        check("rst_wrap", wrap_cnt, 0);

        // ---- burst of 6 with ready held high
        out_ready = 1'b1;
        launch(1'b1, 1'b1, 6);
        for (int i = 0; i < 6; i++) begin
            check("b6_valid", out_valid, 1);
            check("b6_prime", prime, ring[i]);
            check("b6_nodone", done, 0);
            tick();
        end
        check("b6_done", done, 1);
        check("b6_valid_off", out_valid, 0);
        check("b6_prime_end", prime, 2);
        check("b6_wrap", wrap_cnt, 1);
        tick();
        check("b6_done_once", done, 0);
        check("b6_idle", busy, 0);

        // ---- continuous, ready alternating 1/0
        launch(1'b0, 1'b1, 0);
        m_idx = 0;
        for (int c = 0; c < 24; c++) begin
            out_ready = (c % 2 == 0);
            check("cont_valid", out_valid, 1);
            check("cont_prime", prime, ring[m_idx]);
            tick();
            if (c % 2 == 0) m_idx = (m_idx + 1) % 6;
        end
        check("cont_wrap", wrap_cnt, 2);
        out_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("cont_stop_idle", busy, 0);
        check("cont_stop_nodone", done, 0);

        // ---- burst with zero steps
        launch(1'b1, 1'b0, 0);
        check("z_done", done, 1);
        check("z_valid", out_valid, 0);
        check("z_prime", prime, 2);
        tick();
        check("z_done_clr", done, 0);
        check("z_valid2", out_valid, 0);

        // ---- stop without handshake at prime 7
        out_ready = 1'b1;
        launch(1'b0, 1'b1, 0);
        tick(); tick(); tick();
        check("s7_prime", prime, 7);
        out_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("s7_idle", busy, 0);
        check("s7_nodone", done, 0);
        check("s7_held", prime, 7);
        launch(1'b1, 1'b0, 2);
        check("s7_reoffer", prime, 7);
        check("s7_valid", out_valid, 1);

        // ---- stop coinciding with the burst-ending handshake at 11
        out_ready = 1'b1;
        tick();
        check("s11_prime", prime, 11);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        out_ready = 1'b0;
        check("s11_adv", prime, 13);
        check("s11_idle", busy, 0);
        check("s11_nodone", done, 0);
        tick();
        check("s11_nodone2", done, 0);

        // ---- reset in the middle of a burst at prime 5
        out_ready = 1'b1;
        launch(1'b1, 1'b1, 10);
        tick(); tick();
        check("r5_prime", prime, 5);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("r5_valid", out_valid, 0);
        check("r5_busy", busy, 0);
        check("r5_prime2", prime, 2);
        check("r5_wrap", wrap_cnt, 0);
        start = 1'b1;
        tick();
        check("r5_start_ign", busy, 0);
        start = 1'b0;
        rst = 1'b0;
        tick();
        check("r5_idle", out_valid, 0);
        m_idx = 0;

        // ---- randomized launches
        for (int r = 0; r < 30; r++) begin
            b  = bit'($urandom_range(0, 1));
            st = $urandom_range(0, 12);
            if ($urandom_range(0, 1) == 1) begin
                m_idx = 0;
                launch(b, 1'b1, st);
            end else begin
                launch(b, 1'b0, st);
            end
            if (b && st == 0) begin
                check("rnd_zero_done", done, 1);
                check("rnd_zero_prime", prime, ring[m_idx]);
                check("rnd_zero_wrap", wrap_cnt, 0);
                tick();
                continue;
            end
            exp_q.delete();
            for (int k = 0; k < 64; k++) exp_q.push_back(4'(ring[(m_idx + k) % 6]));
            hs_cnt = 0; cyc = 0; ended = 0; exp_done = 0;
            while (!ended && cyc < 200) begin
                check("rnd_valid", out_valid, 1);
                check("rnd_prime", prime, exp_q[0]);
                rdy = bit'($urandom_range(0, 1));
                if (b) stp = ($urandom_range(0, 15) == 0);
                else   stp = (cyc >= 20) || ($urandom_range(0, 15) == 0);
                out_ready = rdy;
                stop      = stp;
                tick();
                if (rdy) begin
                    void'(exp_q.pop_front());
                    hs_cnt++;
                end
                if (stp) ended = 1;
                else if (b && rdy && hs_cnt == st) begin
                    ended = 1;
                    exp_done = 1;
                end
                cyc++;
            end
            out_ready = 1'b0;
            stop = 1'b0;
            check("rnd_ended", 32'(ended), 1);
            check("rnd_done", done, 32'(exp_done));
            check("rnd_busy", busy, 0);
            check("rnd_wrap", wrap_cnt, (m_idx + hs_cnt) / 6);
            m_idx = (m_idx + hs_cnt) % 6;
            check("rnd_prime_end", prime, ring[m_idx]);
            if (exp_done) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
